// File: rtl/reflet_ram_narrow_bridge_pkg.sv
// Shared definitions for the reduced-width narrow RAM bridge.
// State encoding plus the reduced-width to byte-count mapping, which the
// CPU-side reduced-behaviour logic also uses so both ends agree on n.
package reflet_ram_narrow_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_READ_TAIL,
    ST_WRITE,
    ST_DONE
  } bridge_state_t;

  // Number of bytes moved for a given reduced_behavior_bits and word width.
  // A reduction only applies when it is strictly narrower than the word.
  function automatic logic [4:0] reduced_byte_count(input logic [1:0] bits,
                                                    input int unsigned wordsize);
    logic [4:0] full;
    full = 5'(wordsize / 8);
    case (bits)
      2'b01:   return (wordsize > 32) ? 5'd4 : full;
      2'b10:   return (wordsize > 16) ? 5'd2 : full;
      2'b11:   return (wordsize > 8)  ? 5'd1 : full;
      default: return full;
    endcase
  endfunction

endpackage

// File: rtl/reflet_byte_lane_mux.sv
// Combinational byte-lane select and insert for the narrow RAM bridge.
// Byte index k maps to a word lane: lane k (little-endian) by default, or
// lane n-1-k when REFLET_NARROW_BRIDGE_BIG_ENDIAN_EN is defined.
// Lanes outside the word are never selected or written.
module reflet_byte_lane_mux #(
  parameter int wordsize = 16
) (
  input  logic [wordsize-1:0] sel_word,
  input  logic [wordsize-1:0] ins_word,
  input  logic [7:0]          ins_byte,
  input  logic [4:0]          n,
  input  logic [4:0]          k,
  output logic [7:0]          sel_byte,
  output logic [wordsize-1:0] ins_result
);

  localparam int LANES = wordsize / 8;

  logic [4:0] lane;

  // Map byte index to lane, then extract from sel_word and insert into ins_word.
  always_comb begin
`ifdef REFLET_NARROW_BRIDGE_BIG_ENDIAN_EN
    lane = n - 5'd1 - k;
`else
    lane = k;
`endif
    sel_byte   = '0;
    ins_result = ins_word;
    if (int'(lane) < LANES) begin
      sel_byte                        = sel_word[int'(lane)*8 +: 8];
      ins_result[int'(lane)*8 +: 8]   = ins_byte;
    end
  end

endmodule

// File: rtl/reflet_ram_narrow_bridge.sv
// Narrow RAM bridge: executes one CPU word access (full or reduced width)
// on an 8-bit synchronous RAM, one byte per cycle.
// Optional macro REFLET_NARROW_BRIDGE_BIG_ENDIAN_EN selects big-endian
// byte ordering within the n-byte access (little-endian when undefined).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for cpu_req; latches request on acceptance
// READ      | issuing read address base+k, capturing byte k-1
// READ_TAIL | capturing the last byte returned by the RAM
// WRITE     | writing byte k to base+k
// DONE      | cpu_ready high for this single cycle
module reflet_ram_narrow_bridge
  import reflet_ram_narrow_bridge_pkg::*;
#(
  parameter int wordsize = 16,
  parameter int addrsize = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_write,
  input  logic [addrsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_wdata,
  input  logic [1:0]          reduced_behavior_bits,
  output logic [wordsize-1:0] cpu_rdata,
  output logic                cpu_ready,
  output logic [addrsize-1:0] mem_addr,
  output logic [7:0]          mem_wdata,
  output logic                mem_write_en,
  input  logic [7:0]          mem_rdata
);

  bridge_state_t       state;
  logic [addrsize-1:0] base_q;
  logic [wordsize-1:0] wdata_q;
  logic [wordsize-1:0] asm_q;
  logic [4:0]          n_q;
  logic [4:0]          k;
  logic [4:0]          n_in;

  logic [wordsize-1:0] mux_sel_word;
  logic [4:0]          mux_n;
  logic [4:0]          mux_k;
  logic [7:0]          mux_sel_byte;
  logic [wordsize-1:0] mux_ins_result;

  assign n_in = reduced_byte_count(reduced_behavior_bits, wordsize);

  // Lane mux operand select: byte 0 of the incoming word in IDLE, the next
  // byte to write in WRITE, and the byte being captured while reading.
  always_comb begin
    mux_sel_word = wdata_q;
    mux_n        = n_q;
    mux_k        = k - 5'd1;
    case (state)
      ST_IDLE: begin
        mux_sel_word = cpu_wdata;
        mux_n        = n_in;
        mux_k        = 5'd0;
      end
      ST_WRITE: mux_k = k + 5'd1;
      default: ;
    endcase
  end

  reflet_byte_lane_mux #(
    .wordsize(wordsize)
  ) u_lane_mux (
    .sel_word  (mux_sel_word),
    .ins_word  (asm_q),
    .ins_byte  (mem_rdata),
    .n         (mux_n),
    .k         (mux_k),
    .sel_byte  (mux_sel_byte),
    .ins_result(mux_ins_result)
  );

  // Sequencer: all RAM-side and CPU-side outputs are registered and set up
  // one cycle ahead, so the RAM sees address/data in the state that owns them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      base_q       <= '0;
      wdata_q      <= '0;
      asm_q        <= '0;
      n_q          <= '0;
      k            <= '0;
      cpu_rdata    <= '0;
      cpu_ready    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_write_en <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cpu_ready    <= 1'b0;
          mem_write_en <= 1'b0;
          if (cpu_req) begin
            base_q   <= cpu_addr;
            wdata_q  <= cpu_wdata;
            n_q      <= n_in;
            k        <= 5'd0;
            mem_addr <= cpu_addr;
            if (cpu_write) begin
              mem_wdata    <= mux_sel_byte;
              mem_write_en <= 1'b1;
              state        <= ST_WRITE;
            end else begin
              asm_q <= '0;
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          // The RAM returns byte k-1 now; k = 0 has nothing to capture yet.
          if (k != 5'd0) asm_q <= mux_ins_result;
          k <= k + 5'd1;
          if (k == n_q - 5'd1) begin
            state <= ST_READ_TAIL;
          end else begin
            mem_addr <= base_q + addrsize'(k + 5'd1);
          end
        end
        ST_READ_TAIL: begin
          asm_q     <= mux_ins_result;
          cpu_rdata <= mux_ins_result;
          cpu_ready <= 1'b1;
          state     <= ST_DONE;
        end
        ST_WRITE: begin
          if (k == n_q - 5'd1) begin
            mem_write_en <= 1'b0;
            cpu_ready    <= 1'b1;
            state        <= ST_DONE;
          end else begin
            k         <= k + 5'd1;
            mem_addr  <= base_q + addrsize'(k + 5'd1);
            mem_wdata <= mux_sel_byte;
          end
        end
        ST_DONE: begin
          cpu_ready <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_ram_narrow_bridge.sv
// Directed bench for reflet_ram_narrow_bridge: a 32-bit and a 16-bit
// instance share one byte RAM model. Expected values follow
// REFLET_NARROW_BRIDGE_BIG_ENDIAN_EN when defined.
module tb_reflet_ram_narrow_bridge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        req32, wr32;
  logic [15:0] addr32;
  logic [31:0] wdata32, rdata32;
  logic [1:0]  bits32;
  logic        ready32, we32;
  logic [15:0] maddr32;
  logic [7:0]  mwdata32;

  // 16-bit instance
  logic        req16, wr16;
  logic [15:0] addr16;
  logic [15:0] wdata16, rdata16;
  logic [1:0]  bits16;
  logic        ready16, we16;
  logic [15:0] maddr16;
  logic [7:0]  mwdata16;

  logic [7:0]  mem_rdata;

  reflet_ram_narrow_bridge #(.wordsize(32), .addrsize(16)) dut32 (
    .clk(clk), .reset(reset), .cpu_req(req32), .cpu_write(wr32),
    .cpu_addr(addr32), .cpu_wdata(wdata32), .reduced_behavior_bits(bits32),
    .cpu_rdata(rdata32), .cpu_ready(ready32), .mem_addr(maddr32),
    .mem_wdata(mwdata32), .mem_write_en(we32), .mem_rdata(mem_rdata)
  );

  reflet_ram_narrow_bridge #(.wordsize(16), .addrsize(16)) dut16 (
    .clk(clk), .reset(reset), .cpu_req(req16), .cpu_write(wr16),
    .cpu_addr(addr16), .cpu_wdata(wdata16), .reduced_behavior_bits(bits16),
    .cpu_rdata(rdata16), .cpu_ready(ready16), .mem_addr(maddr16),
    .mem_wdata(mwdata16), .mem_write_en(we16), .mem_rdata(mem_rdata)
  );

  // Byte RAM with one-cycle read latency and a bench preload port.
  logic [7:0]  ram [0:65535];
  logic        use16;
  logic        tb_we;
  logic [15:0] tb_a;
  logic [7:0]  tb_d;
  logic [15:0] r_addr;
  logic        r_we;
  logic [7:0]  r_wd;

  always_comb begin
    r_addr = use16 ? maddr16 : maddr32;
    r_we   = use16 ? we16 : we32;
    r_wd   = use16 ? mwdata16 : mwdata32;
  end

  always @(posedge clk) begin
    if (r_we) ram[r_addr] <= r_wd;
    else if (tb_we) ram[tb_a] <= tb_d;
    mem_rdata <= ram[r_addr];
  end

`ifdef REFLET_NARROW_BRIDGE_BIG_ENDIAN_EN
  localparam logic [31:0] E_RD10 = 32'h11223344;
  localparam logic [31:0] E_RD30 = 32'hA1A2A3A4;
  localparam logic [7:0]  E_W20  = 8'hCC;
  localparam logic [7:0]  E_W21  = 8'hDD;
  localparam logic [7:0]  E_FFFF = 8'hBE;
  localparam logic [7:0]  E_0000 = 8'hEF;
  localparam logic [7:0]  E_W40  = 8'h01;
`else
  localparam logic [31:0] E_RD10 = 32'h44332211;
  localparam logic [31:0] E_RD30 = 32'hA4A3A2A1;
  localparam logic [7:0]  E_W20  = 8'hDD;
  localparam logic [7:0]  E_W21  = 8'hCC;
  localparam logic [7:0]  E_FFFF = 8'hEF;
  localparam logic [7:0]  E_0000 = 8'hBE;
  localparam logic [7:0]  E_W40  = 8'h04;
`endif

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    tb_a  = a;
    tb_d  = d;
    tb_we = 1'b1;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // Called in cycle T with the request driven; returns the offset of the
  // cycle carrying cpu_ready (-1 on timeout), then steps into IDLE.
  task automatic wait_ready(input bit w16, output int c, output bit we_seen);
    c = -1;
    we_seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        req32 = 1'b0;
        req16 = 1'b0;
      end
      if (w16 ? we16 : we32) we_seen = 1'b1;
      if (w16 ? ready16 : ready32) begin
        c = i;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  int  cyc, cyc2;
  bit  we_seen, ready_seen;
  logic [31:0] first_rd;

  initial begin
    reset = 1'b1;
    req32 = 0; wr32 = 0; addr32 = 0; wdata32 = 0; bits32 = 0;
    req16 = 0; wr16 = 0; addr16 = 0; wdata16 = 0; bits16 = 0;
    use16 = 0; tb_we = 0; tb_a = 0; tb_d = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata32, 0);
    check("rst_ready", ready32, 0);
    check("rst_maddr", maddr32, 0);
    check("rst_mwdata", mwdata32, 0);
    check("rst_we", we32, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      poke(16'h0010 + 16'(i), 8'h11 * 8'(i + 1));
      poke(16'h0020 + 16'(i), 8'h5A);
      poke(16'h0030 + 16'(i), 8'hA1 + 8'(i));
      poke(16'h0040 + 16'(i), 8'h77);
    end
    poke(16'hFFFF, 8'h66);
    poke(16'h0000, 8'h66);

    // Full 32-bit read
    addr32 = 16'h0010; wr32 = 0; bits32 = 2'b00; req32 = 1;
    wait_ready(0, cyc, we_seen);
    check("rd_full_data", rdata32, E_RD10);
    check("rd_full_lat", cyc, 6);
    check("rd_full_no_we", we_seen, 0);

    // Single-byte read
    addr32 = 16'h0010; bits32 = 2'b11; req32 = 1;
    wait_ready(0, cyc, we_seen);
    check("rd_byte_data", rdata32, 32'h00000011);
    check("rd_byte_lat", cyc, 3);
    check("rd_byte_one_addr", maddr32, 16'h0010);

    // Half-word write
    addr32 = 16'h0020; wr32 = 1; wdata32 = 32'hAABBCCDD; bits32 = 2'b10; req32 = 1;
    wait_ready(0, cyc, we_seen);
    check("wr_half_lat", cyc, 3);
    check("wr_half_b0", ram[16'h0020], E_W20);
    check("wr_half_b1", ram[16'h0021], E_W21);
    check("wr_half_b2", ram[16'h0022], 8'h5A);
    check("wr_half_b3", ram[16'h0023], 8'h5A);
    check("wr_half_we_off", we32, 0);

    // 16-bit full write across the address wrap (bits 01 is not a reduction here)
    use16 = 1;
    addr16 = 16'hFFFF; wr16 = 1; wdata16 = 16'hBEEF; bits16 = 2'b01; req16 = 1;
    wait_ready(1, cyc, we_seen);
    check("wr_wrap_lat", cyc, 3);
    check("wr_wrap_ffff", ram[16'hFFFF], E_FFFF);
    check("wr_wrap_0000", ram[16'h0000], E_0000);
    use16 = 0;

    // Held request: change of cpu_addr mid-read is ignored, second accepted after DONE
    addr32 = 16'h0010; wr32 = 0; bits32 = 2'b00; req32 = 1;
    cyc = -1; cyc2 = -1; first_rd = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 3) addr32 = 16'h0030;
      if (ready32) begin
        if (cyc < 0) begin
          cyc = i;
          first_rd = rdata32;
        end else begin
          cyc2 = i;
          break;
        end
      end
    end
    req32 = 0;
    check("held_first_data", first_rd, E_RD10);
    check("held_first_lat", cyc, 6);
    check("held_second_data", rdata32, E_RD30);
    check("held_second_lat", cyc2, 13);
    @(posedge clk); #1;

    // Reset during a full write, asserted in cycle T+2
    addr32 = 16'h0040; wr32 = 1; wdata32 = 32'h01020304; bits32 = 2'b00; req32 = 1;
    @(posedge clk); #1;
    req32 = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_rdata", rdata32, 0);
    check("abort_ready", ready32, 0);
    check("abort_maddr", maddr32, 0);
    check("abort_mwdata", mwdata32, 0);
    check("abort_we", we32, 0);
    ready_seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready32) ready_seen = 1;
    end
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready32) ready_seen = 1;
    end
    check("abort_no_ready", ready_seen, 0);
    check("abort_b0", ram[16'h0040], E_W40);
    check("abort_b1", ram[16'h0041], 8'h77);
    check("abort_b2", ram[16'h0042], 8'h77);
    check("abort_b3", ram[16'h0043], 8'h77);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
